// File: rtl/mainfsm_pkg.sv
// Shared control definitions for the multicycle controller: the state encoding, the
// datapath mux select codes and the opcode field values.
package mainfsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        ALUWB2   = 4'd9,
        BRANCH   = 4'd10,
        UNKNOWN  = 4'd11
    } statetype;

    // ALU operand A select
    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;
    localparam logic [1:0] SRCA_PC8 = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    // Register-file / PC result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Op field values
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Funct bit positions
    localparam int FUNCT_I = 5;
    localparam int FUNCT_L = 0;

    // Dispatch target out of DECODE for a given opcode class.
    function automatic statetype decode_target(input logic [1:0] op, input logic imm);
        statetype target;
        case (op)
            OP_MEM:  target = MEMADR;
            OP_DP:   target = imm ? EXECUTEI : EXECUTER;
            OP_BR:   target = BRANCH;
            default: target = UNKNOWN;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/mainfsm_outdec.sv
// State-to-control decode for mainfsm. Purely combinational; unused encodings decode
// to all-zero so no strobe can fire from an illegal state.
module mainfsm_outdec
    import mainfsm_pkg::*;
(
    input  logic [3:0] state,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       RegSrc64b,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc
);

    statetype st;
    assign st = statetype'(state);

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        RegSrc64b = 1'b0;
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        case (st)
            FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALU;
            end
            DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALU;
            end
            MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = RES_DATA;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            EXECUTER: begin
                ALUOp   = 1'b1;
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_REG;
            end
            EXECUTEI: begin
                ALUOp   = 1'b1;
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            ALUWB: begin
                RegW      = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            ALUWB2: begin
                RegW      = 1'b1;
                RegSrc64b = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            BRANCH: begin
                Branch    = 1'b1;
                ALUSrcA   = SRCA_PC8;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main controller: Moore FSM stepping each instruction through its
// fetch/decode/execute/writeback states. Outputs depend only on the state register.
module mainfsm
    import mainfsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       Mul64,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       RegSrc64b,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc
);

    statetype state_reg;
    statetype state_next;

    // Only the immediate and load bits of Funct steer sequencing.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:    state_next = DECODE;
            DECODE:   state_next = decode_target(Op, Funct[FUNCT_I]);
            MEMADR:   state_next = Funct[FUNCT_L] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = Mul64 ? ALUWB2 : FETCH;
            default:  state_next = FETCH;
        endcase
    end

    mainfsm_outdec u_outdec (
        .state     (state_reg),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .RegSrc64b (RegSrc64b),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc)
    );

endmodule

// File: tb/tb_mainfsm.sv
// Bench for mainfsm: per-instruction control sequences from a table, random instruction
// streams against an instruction-level plan, and asynchronous reset corner cases.
module tb_mainfsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       Mul64;
    logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, RegSrc64b;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

    int checks = 0;
    int errors = 0;

    mainfsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .Mul64     (Mul64),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .RegSrc64b (RegSrc64b),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IRWrite,AdrSrc,NextPC,RegW,MemW,Branch,ALUOp,RegSrc64b,ALUSrcA,ALUSrcB,ResultSrc}
    logic [13:0] outv;
    assign outv = {IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, RegSrc64b,
                   ALUSrcA, ALUSrcB, ResultSrc};

    typedef enum {L_FETCH, L_DECODE, L_MEMADR, L_MEMREAD, L_MEMWB, L_MEMWRITE,
                  L_EXECR, L_EXECI, L_ALUWB, L_ALUWB2, L_BRANCH, L_UNKNOWN} lbl_t;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [5:0] funct;
        logic       m64;
        int         exp_len;
    } vec_t;

    // Control word each step of an instruction must present.
    function automatic logic [13:0] exp_row(input lbl_t l);
        logic [7:0] s;
        logic [1:0] a, b, r;
        s = 8'b0; a = 2'b00; b = 2'b00; r = 2'b00;
        case (l)
            L_FETCH:    begin s = 8'b1010_0000; a = 2'b01; b = 2'b10; r = 2'b10; end
            L_DECODE:   begin a = 2'b01; b = 2'b10; r = 2'b10; end
            L_MEMADR:   begin b = 2'b01; end
            L_MEMREAD:  begin s = 8'b0100_0000; end
            L_MEMWB:    begin s = 8'b0001_0000; r = 2'b01; end
            L_MEMWRITE: begin s = 8'b0100_1000; end
            L_EXECR:    begin s = 8'b0000_0010; end
            L_EXECI:    begin s = 8'b0000_0010; b = 2'b01; end
            L_ALUWB:    begin s = 8'b0001_0000; end
            L_ALUWB2:   begin s = 8'b0001_0001; end
            L_BRANCH:   begin s = 8'b0000_0100; a = 2'b10; b = 2'b01; r = 2'b10; end
            default:    ;
        endcase
        return {s, a, b, r};
    endfunction

    // Instruction-level plan: which steps an instruction walks through.
    function automatic int plan(input logic [1:0] op, input logic [5:0] f, input logic m,
                                output lbl_t p[8]);
        int n;
        for (int i = 0; i < 8; i++) p[i] = L_FETCH;
        p[1] = L_DECODE;
        case (op)
            2'b01: begin
                p[2] = L_MEMADR;
                if (f[0]) begin p[3] = L_MEMREAD; p[4] = L_MEMWB; n = 5; end
                else      begin p[3] = L_MEMWRITE; n = 4; end
            end
            2'b00: begin
                p[2] = f[5] ? L_EXECI : L_EXECR;
                p[3] = L_ALUWB;
                if (m) begin p[4] = L_ALUWB2; n = 5; end
                else   n = 4;
            end
            2'b10:   begin p[2] = L_BRANCH; n = 3; end
            default: begin p[2] = L_UNKNOWN; n = 3; end
        endcase
        return n;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ctrl=%b expected=%b", nm, act, exp);
        end
    endtask

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 of the next FETCH.
    task automatic run_instr(input string nm, input logic [1:0] op, input logic [5:0] funct,
                             input logic m64, input int exp_len);
        lbl_t p[8];
        int   n;
        int   cyc;
        n = plan(op, funct, m64, p);
        chk({nm, ":fetch"}, outv, exp_row(L_FETCH));
        Op = 2'($urandom); Funct = 6'($urandom); Mul64 = 1'($urandom);
        tick;
        Op = op; Funct = funct; Mul64 = m64;
        cyc = 1;
        while (cyc < 12 && IRWrite !== 1'b1) begin
            chk($sformatf("%s:step%0d", nm, cyc), outv, exp_row(cyc < n ? p[cyc] : L_FETCH));
            tick;
            cyc++;
        end
        checks++;
        if (cyc != exp_len) begin
            errors++;
            $display("FAIL %s:latency cycles=%0d expected=%0d", nm, cyc, exp_len);
        end
        $display("instr %s op=%b funct=%b mul64=%b cycles=%0d", nm, op, funct, m64, cyc);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"LDR",    2'b01, 6'b011001, 1'b0, 5};
        vecs[1] = '{"STR",    2'b01, 6'b011000, 1'b0, 4};
        vecs[2] = '{"ADDI",   2'b00, 6'b101000, 1'b0, 4};
        vecs[3] = '{"ADDR",   2'b00, 6'b001001, 1'b0, 4};
        vecs[4] = '{"UMULL",  2'b00, 6'b000000, 1'b1, 5};
        vecs[5] = '{"MULI64", 2'b00, 6'b100001, 1'b1, 5};
        vecs[6] = '{"B",      2'b10, 6'b111111, 1'b1, 3};
        vecs[7] = '{"UNK",    2'b11, 6'b111111, 1'b1, 3};
        vecs[8] = '{"STR64",  2'b01, 6'b111110, 1'b1, 4};

        reset = 1'b1; Op = 2'b00; Funct = 6'b0; Mul64 = 1'b0;
        #2;
        chk("reset_async", outv, exp_row(L_FETCH));
        for (int i = 0; i < 3; i++) begin
            Op = 2'b01; Funct = 6'b011001;
            tick;
            chk($sformatf("reset_hold%0d", i), outv, exp_row(L_FETCH));
        end
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_instr(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].m64, vecs[i].exp_len);

        // Reset between edges while MemW is high: abort the store immediately.
        chk("mid:fetch", outv, exp_row(L_FETCH));
        tick;
        Op = 2'b01; Funct = 6'b011000; Mul64 = 1'b0;
        tick;
        tick;
        chk("mid:memwrite", outv, exp_row(L_MEMWRITE));
        #3 reset = 1'b1;
        #1 chk("mid:async_fetch", outv, exp_row(L_FETCH));
        tick;
        chk("mid:held1", outv, exp_row(L_FETCH));
        tick;
        chk("mid:held2", outv, exp_row(L_FETCH));
        #2 reset = 1'b0;
        #1 chk("mid:released", outv, exp_row(L_FETCH));
        Op = 2'b10;
        tick;
        chk("mid:decode", outv, exp_row(L_DECODE));
        tick;
        chk("mid:branch", outv, exp_row(L_BRANCH));
        tick;
        $display("instr reset-during-store aborted, branch follows");

        // Reset during the second writeback of a long multiply.
        chk("mul:fetch", outv, exp_row(L_FETCH));
        tick;
        Op = 2'b00; Funct = 6'b000000; Mul64 = 1'b1;
        tick; tick; tick;
        chk("mul:aluwb2", outv, exp_row(L_ALUWB2));
        #2 reset = 1'b1;
        #1 chk("mul:async_fetch", outv, exp_row(L_FETCH));
        tick;
        reset = 1'b0;
        $display("instr reset-during-aluwb2 aborted");

        for (int i = 0; i < 80; i++) begin
            logic [1:0] rop;
            logic [5:0] rf;
            logic       rm;
            lbl_t       rp[8];
            int         rn;
            rop = 2'($urandom_range(0, 3));
            rf  = 6'($urandom);
            rm  = 1'($urandom);
            rn  = plan(rop, rf, rm, rp);
            run_instr($sformatf("rnd%0d", i), rop, rf, rm, rn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
